// File: rtl/serial_pkg.sv
// Types and defaults shared by the serializer and deserializer.
package serial_pkg;

    localparam int unsigned WORD_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } serial_state_e;

endpackage

// File: rtl/piso_reg.sv
// Parallel-in / serial-out shift register.
// The head bit is the next bit to go out on the line.
module piso_reg
    import serial_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] data_i,
    output logic              head_o
);

    logic [WORD_W-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            // Vacated positions fill with zero.
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[WORD_W-1:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign head_o = MSB_FIRST ? shreg_q[WORD_W-1] : shreg_q[0];

endmodule

// File: rtl/serializador.sv
// Word-to-bit serializer: accepts a parallel word with valid/ready and emits it one bit
// per write_out strobe, paced by the downstream status_in flow control.
module serializador
    import serial_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clock_100khz,
    input  logic              reset,
    input  logic [WORD_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              status_in,
    output logic              data_out,
    output logic              write_out,
    output logic              done_out
);

    localparam int unsigned      CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    serial_state_e    state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             data_q, data_d;
    logic             write_q, write_d;
    logic             done_q, done_d;
    logic             load_en;
    logic             shift_en;
    logic             head_bit;

    piso_reg #(
        .WORD_W   (WORD_W),
        .MSB_FIRST(MSB_FIRST)
    ) u_piso_reg (
        .clock  (clock_100khz),
        .reset  (reset),
        .load_i (load_en),
        .shift_i(shift_en),
        .data_i (data_in),
        .head_o (head_bit)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    load_en   = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (status_in) begin
                    shift_en = 1'b1;
                    data_d   = head_bit;
                    write_d  = 1'b1;
                    // done_out is registered alongside the final strobe.
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100khz) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= 1'b0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            write_q   <= write_d;
            done_q    <= done_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign data_out  = data_q;
    assign write_out = write_q;
    assign done_out  = done_q;

endmodule
